// File: rtl/uart_ddr_pkg.sv
// Shared types and defaults for the UART-to-DDR write path.
package uart_ddr_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 16;

    typedef logic [BYTE_W-1:0]     byte_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    // State of the single-word pending register in front of the FIFO.
    typedef enum logic {
        PendEmpty,
        PendHeld
    } pend_state_e;

endpackage

// File: rtl/uart_word_packer_if.sv
// UART byte input and async-FIFO write port of the word packer.
interface uart_word_packer_if #(
    parameter int unsigned DATA_WIDTH = uart_ddr_pkg::DATA_WIDTH
) ();

    logic                    rx_valid;
    uart_ddr_pkg::byte_t     rx_data;
    logic                    full;
    logic                    w_en;
    logic [DATA_WIDTH-1:0]   wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  full,
        output w_en,
        output wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output full,
        input  w_en,
        input  wdata
    );

endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes into little-endian FIFO words behind a one-word pending register.
// Define PACKER_TIMEOUT_FLUSH_EN to flush partial words after TIMEOUT_CYCLES idle cycles.
module uart_word_packer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 wclk,
    input  logic                 wrst,
    uart_word_packer_if.master   bus,
    input  logic                 ovf_clr,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] words_written,
    output logic [CNT_WIDTH-1:0] words_dropped
);

    import uart_ddr_pkg::*;

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / BYTE_W;
    localparam int unsigned IDX_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned ACC_W    = DATA_WIDTH - BYTE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]      idx_q, idx_d;
    // Only the lower bytes are stored; the last byte goes straight into the word.
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DATA_WIDTH-1:0] done_word;
    logic                  word_done;
    logic                  flush;

    pend_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] pend_q;
    logic                  drain, load, drop;

    logic                  ovf_q;
    logic [CNT_WIDTH-1:0]  ww_q, wd_q;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] idle_q;

    assign flush = !bus.rx_valid && (idx_q != '0) && (idle_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wclk) begin
        if (wrst || bus.rx_valid || flush) begin
            idle_q <= '0;
        end else if (idx_q != '0) begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;

    assign flush          = 1'b0;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        idx_d     = idx_q;
        acc_d     = acc_q;
        word_done = 1'b0;
        done_word = {bus.rx_data, acc_q};
        if (bus.rx_valid) begin
            if (idx_q == LAST_IDX) begin
                idx_d     = '0;
                acc_d     = '0;
                word_done = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
                acc_d[idx_q*BYTE_W +: BYTE_W] = bus.rx_data;
            end
        end else if (flush) begin
            // Missing upper bytes are already zero because acc clears on every word.
            idx_d     = '0;
            acc_d     = '0;
            word_done = 1'b1;
            done_word = {{BYTE_W{1'b0}}, acc_q};
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= PendEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PendEmpty: if (word_done) state_d = PendHeld;
            PendHeld:  if (drain && !word_done) state_d = PendEmpty;
            default:   state_d = PendEmpty;
        endcase
    end

    always_comb begin
        drain = (state_q == PendHeld) && !bus.full;
        load  = word_done && ((state_q == PendEmpty) || drain);
        drop  = word_done && (state_q == PendHeld) && !drain;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
            ww_q   <= '0;
            wd_q   <= '0;
        end else begin
            if (load) begin
                pend_q <= done_word;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (drain) begin
                ww_q <= ww_q + 1'b1;
            end
            if (drop && (wd_q != '1)) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    assign bus.w_en      = drain;
    assign bus.wdata     = pend_q;
    assign overflow      = ovf_q;
    assign words_written = ww_q;
    assign words_dropped = wd_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Self-checking bench for uart_word_packer: directed table, corner sequences, random vs model.
module tb_uart_word_packer;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 4;
    localparam int unsigned TMO = 16;
    localparam int unsigned BPW = DW / 8;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          ovf_clr;
    logic          overflow;
    logic [CW-1:0] words_written;
    logic [CW-1:0] words_dropped;

    uart_word_packer_if #(.DATA_WIDTH(DW)) bus ();

    uart_word_packer #(
        .DATA_WIDTH     (DW),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .bus           (bus.master),
        .ovf_clr       (ovf_clr),
        .overflow      (overflow),
        .words_written (words_written),
        .words_dropped (words_dropped)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rxv;
        logic [7:0]    d;
        logic          f;
        logic          clr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic          ovf;
        logic [CW-1:0] ww;
        logic [CW-1:0] wd;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: bytes of the word in progress, the pending word, counters.
    logic [7:0]    m_part[$];
    int            m_quiet;
    bit            m_has_pend;
    logic [DW-1:0] m_pend;
    bit            m_ovf;
    int            m_ww;
    int            m_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rxv, input logic [7:0] d, input logic f, input logic clr);
        bus.rx_valid = rxv;
        bus.rx_data  = d;
        bus.full     = f;
        ovf_clr      = clr;
        #3;
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        wrst = 1'b0;
    endtask

    function automatic vec_t v(input logic rxv, input logic [7:0] d, input logic f,
                               input logic wen, input logic [DW-1:0] wdata, input logic ovf,
                               input logic [CW-1:0] ww, input logic [CW-1:0] wd);
        vec_t r;
        r.rxv = rxv; r.d = d; r.f = f; r.clr = 1'b0;
        r.wen = wen; r.wdata = wdata; r.ovf = ovf; r.ww = ww; r.wd = wd;
        return r;
    endfunction

    task automatic model_reset();
        m_part.delete();
        m_quiet    = 0;
        m_has_pend = 1'b0;
        m_pend     = '0;
        m_ovf      = 1'b0;
        m_ww       = 0;
        m_wd       = 0;
    endtask

    task automatic model_step(input bit rxv, input logic [7:0] d, input bit f, input bit clr);
        bit            drain;
        bit            done;
        bit            dropped;
        logic [DW-1:0] word;
        drain   = m_has_pend && !f;
        done    = 1'b0;
        dropped = 1'b0;
        word    = '0;
        if (rxv) begin
            m_part.push_back(d);
            m_quiet = 0;
            if (m_part.size() == BPW) begin
                for (int k = 0; k < BPW; k++) word |= DW'(m_part[k]) << (8 * k);
                m_part.delete();
                done = 1'b1;
            end
        end else if (m_part.size() > 0) begin
`ifdef PACKER_TIMEOUT_FLUSH_EN
            if (m_quiet == TMO - 1) begin
                for (int k = 0; k < m_part.size(); k++) word |= DW'(m_part[k]) << (8 * k);
                m_part.delete();
                m_quiet = 0;
                done    = 1'b1;
            end else begin
                m_quiet++;
            end
`endif
        end
        if (drain) m_ww = (m_ww + 1) % (1 << CW);
        if (done) begin
            if (!m_has_pend || drain) begin
                m_has_pend = 1'b1;
                m_pend     = word;
            end else begin
                dropped = 1'b1;
                m_ovf   = 1'b1;
                if (m_wd < (1 << CW) - 1) m_wd++;
            end
        end else if (drain) begin
            m_has_pend = 1'b0;
        end
        if (clr && !dropped) m_ovf = 1'b0;
    endtask

    initial begin
        int            seen_at;
        logic [DW-1:0] seen_word;
        bit            full_mode;

        do_reset();
        do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_w_en", 64'(bus.w_en), 64'd0);
        check("reset_wdata", 64'(bus.wdata), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_written", 64'(words_written), 64'd0);
        check("reset_dropped", 64'(words_dropped), 64'd0);
        tick();

        // Basic word, then full-held drop and release.
        tbl.push_back(v(1, 8'h11, 0, 0, '0, 0, 0, 0));
        tbl.push_back(v(1, 8'h22, 0, 0, '0, 0, 0, 0));
        tbl.push_back(v(1, 8'h33, 0, 0, '0, 0, 0, 0));
        tbl.push_back(v(1, 8'h44, 0, 0, '0, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 32'h44332211, 0, 1'b0, 0));
        tbl.push_back(v(0, 8'h00, 0, 0, '0, 0, 1, 0));
        for (int i = 1; i <= 8; i++) tbl.push_back(v(1, 8'(i), 1, 0, '0, 0, 1, 0));
        tbl.push_back(v(0, 8'h00, 1, 0, '0, 1, 1, 1));
        tbl.push_back(v(0, 8'h00, 0, 1, 32'h04030201, 1, 1, 1));
        tbl.push_back(v(0, 8'h00, 0, 0, '0, 1, 2, 1));
        foreach (tbl[i]) begin
            drive(tbl[i].rxv, tbl[i].d, tbl[i].f, tbl[i].clr);
            check($sformatf("tbl%0d_w_en", i), 64'(bus.w_en), 64'(tbl[i].wen));
            if (tbl[i].wen) check($sformatf("tbl%0d_wdata", i), 64'(bus.wdata), 64'(tbl[i].wdata));
            check($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'(tbl[i].ovf));
            check($sformatf("tbl%0d_written", i), 64'(words_written), 64'(tbl[i].ww));
            check($sformatf("tbl%0d_dropped", i), 64'(words_dropped), 64'(tbl[i].wd));
            tick();
        end

        // Clear colliding with a new drop: set wins; a lone clear then takes effect.
        for (int i = 0; i < 4; i++) begin drive(1'b1, 8'hA1 + 8'(i), 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 3; i++) begin drive(1'b1, 8'hB1 + 8'(i), 1'b1, 1'b0); tick(); end
        drive(1'b1, 8'hB4, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check("clr_vs_drop_overflow", 64'(overflow), 64'd1);
        check("clr_vs_drop_dropped", 64'(words_dropped), 64'd2);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("clr_alone_overflow", 64'(overflow), 64'd0);
        check("clr_alone_dropped", 64'(words_dropped), 64'd2);
        tick();

        // Full releases in the very cycle the next word completes.
        for (int i = 0; i < 3; i++) begin drive(1'b1, 8'hC1 + 8'(i), 1'b1, 1'b0); tick(); end
        drive(1'b1, 8'hC4, 1'b0, 1'b0);
        check("release_w_en", 64'(bus.w_en), 64'd1);
        check("release_wdata", 64'(bus.wdata), 64'hA4A3A2A1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("reload_w_en", 64'(bus.w_en), 64'd1);
        check("reload_wdata", 64'(bus.wdata), 64'hC4C3C2C1);
        check("reload_overflow", 64'(overflow), 64'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("reload_idle_w_en", 64'(bus.w_en), 64'd0);
        check("reload_written", 64'(words_written), 64'd4);
        check("reload_dropped", 64'(words_dropped), 64'd2);
        tick();

        // Reset with a pending word, then reset mid-word.
        for (int i = 0; i < 4; i++) begin drive(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b0); tick(); end
        do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_pend_w_en", 64'(bus.w_en), 64'd0);
        check("rst_pend_wdata", 64'(bus.wdata), 64'd0);
        tick();
        drive(1'b1, 8'hAA, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hBB, 1'b0, 1'b0); tick();
        do_reset();
        for (int i = 1; i <= 4; i++) begin drive(1'b1, 8'(i), 1'b0, 1'b0); tick(); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_mid_w_en", 64'(bus.w_en), 64'd1);
        check("rst_mid_wdata", 64'(bus.wdata), 64'h04030201);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_mid_written", 64'(words_written), 64'd1);
        check("rst_mid_overflow", 64'(overflow), 64'd0);
        tick();

        // Partial word followed by silence.
        drive(1'b1, 8'hDE, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hAD, 1'b0, 1'b0); tick();
        seen_at   = -1;
        seen_word = '0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            if (bus.w_en && seen_at < 0) begin
                seen_at   = i;
                seen_word = bus.wdata;
            end
            tick();
        end
`ifdef PACKER_TIMEOUT_FLUSH_EN
        check("flush_cycle", 64'(seen_at), 64'(TMO));
        check("flush_wdata", 64'(seen_word), 64'h0000ADDE);
`else
        check("no_flush_cycle", 64'(seen_at), 64'hFFFF_FFFF_FFFF_FFFF);
        check("no_flush_written", 64'(words_written), 64'd1);
`endif

        // Randomized run against the reference model; small CW exercises wrap and saturation.
        do_reset();
        model_reset();
        full_mode = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit         rxv;
            logic [7:0] d;
            bit         clr;
            bit         f;
            if ($urandom_range(0, 15) == 0) full_mode = ~full_mode;
            rxv = ((cyc % 300) < 270) && ($urandom_range(0, 2) != 0);
            d   = 8'($urandom);
            f   = full_mode ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 19) == 0);
            drive(rxv, d, f, clr);
            check($sformatf("rnd%0d_w_en", cyc), 64'(bus.w_en), 64'(m_has_pend && !f));
            if (m_has_pend && !f) check($sformatf("rnd%0d_wdata", cyc), 64'(bus.wdata), 64'(m_pend));
            check($sformatf("rnd%0d_overflow", cyc), 64'(overflow), 64'(m_ovf));
            check($sformatf("rnd%0d_written", cyc), 64'(words_written), 64'(m_ww));
            check($sformatf("rnd%0d_dropped", cyc), 64'(words_dropped), 64'(m_wd));
            model_step(rxv, d, f, clr);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
